// File: rtl/imem_boot_controller_pkg.sv
// Shared definitions for the instruction-memory boot controller and the CPU top level:
// state encodings and default memory geometry.
package imem_boot_controller_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 10;
  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } boot_state_t;

endpackage

// File: rtl/imem_boot_controller.sv
// Owns the instruction RAM ports: streams a program image in from the loader,
// then releases the CPU and serves registered fetches until a reload is requested.
module imem_boot_controller
  import imem_boot_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  input  logic                  reload_req,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  output logic                  cpu_run,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic                  load_error,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  boot_state_t           state;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic                  full;
  logic                  accept;

  // The write pointer is the low bits of the word counter; the extra MSB marks a
  // full memory, after which further words are swallowed instead of wrapping.
  assign wr_ptr = count[ADDR_WIDTH-1:0];
  assign full   = count[ADDR_WIDTH];
  assign accept = (state == ST_LOAD) && load_valid;

  assign load_ready = (state == ST_LOAD);
  assign load_count = count;
  assign ram_we     = accept && !full;
  assign ram_addr   = (state == ST_RUN) ? fetch_addr : wr_ptr;
  assign ram_wdata  = load_data;

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // flop samples pre-edge values, regardless of statement order in this block.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_LOAD;
      count       <= '0;
      load_error  <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
      cpu_run     <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      unique case (state)
        ST_LOAD: begin
          if (accept) begin
            if (full) load_error <= 1'b1;
            else      count      <= count + (ADDR_WIDTH+1)'(1);
            if (load_last) begin
              state   <= ST_RUN;
              cpu_run <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // A reload in the same cycle as a fetch drops the fetch.
          if (reload_req) begin
            state   <= ST_FLUSH;
            cpu_run <= 1'b0;
          end else if (fetch_req) begin
            instr       <= ram_rdata;
            instr_valid <= 1'b1;
          end
        end
        ST_FLUSH: begin
          count      <= '0;
          load_error <= 1'b0;
          state      <= ST_LOAD;
        end
        default: begin
          state   <= ST_LOAD;
          cpu_run <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_controller.sv
// Scoreboard bench for imem_boot_controller: expected fetch responses are queued at
// issue and popped by a monitor whenever instr_valid is presented.
module tb_imem_boot_controller;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_last = 1'b0;
  logic          load_ready;
  logic          reload_req = 1'b0;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          cpu_run;
  logic [AW:0]   load_count;
  logic          load_error;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] ram_mem [1 << AW];
  logic [DW-1:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  imem_boot_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock       (clock),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .reload_req  (reload_req),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .cpu_run     (cpu_run),
    .load_count  (load_count),
    .load_error  (load_error),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  always #5 clock = ~clock;

  // External instruction RAM: synchronous write, combinational read.
  initial foreach (ram_mem[i]) ram_mem[i] = '0;
  always @(posedge clock) if (ram_we) ram_mem[ram_addr] <= ram_wdata;
  assign ram_rdata = ram_mem[ram_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && instr_valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected instr_valid", 64'(instr_valid), 64'd0);
      else check("fetch instr", 64'(instr), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [DW-1:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] e);
    fetch_req  = 1'b1;
    fetch_addr = a;
    exp_q.push_back(e);
    tick();
    fetch_req = 1'b0;
  endtask

  // One edge into FLUSH, one edge back into LOAD.
  task automatic reload();
    reload_req = 1'b1;
    tick();
    reload_req = 1'b0;
    tick();
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst load_ready", 64'(load_ready), 64'd1);
    check("rst cpu_run", 64'(cpu_run), 64'd0);
    check("rst load_count", 64'(load_count), 64'd0);
    check("rst instr", 64'(instr), 64'd0);
    check("rst instr_valid", 64'(instr_valid), 64'd0);
    check("rst load_error", 64'(load_error), 64'd0);
    check("rst ram_we", 64'(ram_we), 64'd0);
    check("rst ram_addr", 64'(ram_addr), 64'd0);

    // Two-word image
    load_valid = 1'b1;
    load_data  = 32'h5800_0000;
    #1;
    check("load ram_we", 64'(ram_we), 64'd1);
    check("load ram_addr", 64'(ram_addr), 64'd0);
    tick();
    load_valid = 1'b0;
    check("cpu_run mid load", 64'(cpu_run), 64'd0);
    load_word(32'h5810_0000, 1'b1);
    check("mem0", 64'(ram_mem[0]), 64'h5800_0000);
    check("mem1", 64'(ram_mem[1]), 64'h5810_0000);
    check("count 2", 64'(load_count), 64'd2);
    check("cpu_run after last", 64'(cpu_run), 64'd1);
    check("ready in run", 64'(load_ready), 64'd0);

    // Fetches
    fetch(10'd1, 32'h5810_0000);
    check("fetch valid", 64'(instr_valid), 64'd1);
    tick();
    check("idle valid", 64'(instr_valid), 64'd0);
    check("idle instr held", 64'(instr), 64'h5810_0000);
    fetch(10'd0, 32'h5800_0000);
    fetch(10'd1, 32'h5810_0000);

    // load_valid in RUN has no effect
    load_valid = 1'b1;
    load_data  = 32'hFFFF_FFFF;
    #1;
    check("run ram_we", 64'(ram_we), 64'd0);
    tick();
    load_valid = 1'b0;
    check("run count held", 64'(load_count), 64'd2);
    check("run mem2 untouched", 64'(ram_mem[2]), 64'd0);

    // Overflowing image
    reload();
    for (int i = 0; i < 1024; i++) load_word(32'hA000_0000 | 32'(i), 1'b0);
    check("full count", 64'(load_count), 64'd1024);
    check("full no error yet", 64'(load_error), 64'd0);
    load_valid = 1'b1;
    load_data  = 32'hDEAD_BEEF;
    load_last  = 1'b1;
    #1;
    check("overflow ram_we", 64'(ram_we), 64'd0);
    check("overflow ready", 64'(load_ready), 64'd1);
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    check("overflow count", 64'(load_count), 64'd1024);
    check("overflow error", 64'(load_error), 64'd1);
    check("overflow mem0 kept", 64'(ram_mem[0]), 64'hA000_0000);
    check("overflow cpu_run", 64'(cpu_run), 64'd1);
    fetch(10'd1023, 32'hA000_03FF);
    fetch(10'd0, 32'hA000_0000);

    // Reload together with a fetch: fetch dropped, one FLUSH cycle
    reload_req = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 10'd3;
    tick();
    reload_req = 1'b0;
    fetch_req  = 1'b0;
    check("flush valid", 64'(instr_valid), 64'd0);
    check("flush cpu_run", 64'(cpu_run), 64'd0);
    check("flush ready", 64'(load_ready), 64'd0);
    tick();
    check("reload ready", 64'(load_ready), 64'd1);
    check("reload count", 64'(load_count), 64'd0);
    check("reload error clr", 64'(load_error), 64'd0);
    load_word(32'h1234_5678, 1'b1);
    check("new mem0", 64'(ram_mem[0]), 64'h1234_5678);
    check("new count", 64'(load_count), 64'd1);
    fetch(10'd0, 32'h1234_5678);
    fetch(10'd5, 32'hA000_0005);

    // Reset mid-load
    reload();
    for (int i = 0; i < 3; i++) load_word(32'hB000_0000 | 32'(i), 1'b0);
    check("partial count", 64'(load_count), 64'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst count", 64'(load_count), 64'd0);
    check("midrst cpu_run", 64'(cpu_run), 64'd0);
    check("midrst ram_addr", 64'(ram_addr), 64'd0);
    check("midrst ready", 64'(load_ready), 64'd1);
    check("midrst instr", 64'(instr), 64'd0);
    check("partial mem2", 64'(ram_mem[2]), 64'hB000_0002);
    for (int i = 0; i < 5; i++) load_word(32'hC000_0000 | 32'(i), i == 4);
    check("five count", 64'(load_count), 64'd5);
    check("five mem4", 64'(ram_mem[4]), 64'hC000_0004);
    check("five cpu_run", 64'(cpu_run), 64'd1);
    fetch(10'd2, 32'hC000_0002);

    // Idle LOAD: fetches and reload ignored
    reload();
    for (int i = 0; i < 20; i++) begin
      fetch_req  = i[0];
      fetch_addr = 10'(i);
      reload_req = (i == 10);
      tick();
      check("idle load ram_we", 64'(ram_we), 64'd0);
      check("idle load cpu_run", 64'(cpu_run), 64'd0);
    end
    fetch_req  = 1'b0;
    reload_req = 1'b0;
    check("idle load ready", 64'(load_ready), 64'd1);
    check("idle load count", 64'(load_count), 64'd0);
    check("idle load mem0", 64'(ram_mem[0]), 64'hC000_0000);

    tick();
    tick();
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
